// File: rtl/diff_pkg.sv
// Shared types and constants for the difftest commit queue.
// Payload widths and the write-back normalisation live here so the queue and its storage agree.
package diff_pkg;

  localparam int DIFF_IDX_W = 8;
  localparam int PC_W       = 64;
  localparam int INSTR_W    = 32;
  localparam int WDEST_W    = 8;
  localparam int WDATA_W    = 64;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               skip;
    logic               wen;
    logic [WDEST_W-1:0] wdest;
    logic [WDATA_W-1:0] wdata;
  } commit_entry_t;

  // Register x0 is never written, so a write to it is recorded as no write with zero data.
  function automatic commit_entry_t normalise_commit(
    input logic [PC_W-1:0]    pc,
    input logic [INSTR_W-1:0] instr,
    input logic               skip,
    input logic               wen,
    input logic [WDEST_W-1:0] wdest,
    input logic [WDATA_W-1:0] wdata
  );
    commit_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    e.skip  = skip;
    e.wen   = wen && (wdest != '0);
    e.wdest = wdest;
    e.wdata = e.wen ? wdata : '0;
    return e;
  endfunction

endpackage

// File: rtl/diff_commit_mem.sv
// Commit record storage: DEPTH registers, one synchronous write port, one asynchronous read port.
// No reset on the array; stale contents are never visible because the queue masks them by occupancy.
module diff_commit_mem
  import diff_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  commit_entry_t wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output commit_entry_t rd_data_o
);

  commit_entry_t mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/diff_commit_queue.sv
// In-order queue between writeback commits and the difftest consumer.
// Handshake: a push happens when in_valid && in_ready, a pop when out_valid && out_ready; both are
// accepted on the rising clock edge and outputs depend only on registered state.
module diff_commit_queue
  import diff_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int IDX_W = DIFF_IDX_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_skip,
  input  logic               in_wen,
  input  logic [WDEST_W-1:0] in_wdest,
  input  logic [WDATA_W-1:0] in_wdata,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_index,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_skip,
  output logic               out_wen,
  output logic [WDEST_W-1:0] out_wdest,
  output logic [WDATA_W-1:0] out_wdata,
  output logic [CNT_W-1:0]   count,
  output logic               err_overflow
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] pop_idx_q, pop_idx_d;
  logic             err_q, err_d;

  logic          push;
  logic          pop;
  commit_entry_t wr_entry;
  commit_entry_t rd_entry;

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_entry = normalise_commit(in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata);

  diff_commit_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clock     (clock),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_entry)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pop_idx_d = pop_idx_q;
    err_d     = err_q || (in_valid && !in_ready);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      pop_idx_d = pop_idx_q + IDX_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pop_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pop_idx_q <= pop_idx_d;
      err_q     <= err_d;
    end
  end

  // The record is zeroed whenever the queue is empty so the consumer never sees stale data.
  assign out_index    = out_valid ? pop_idx_q      : '0;
  assign out_pc       = out_valid ? rd_entry.pc    : '0;
  assign out_instr    = out_valid ? rd_entry.instr : '0;
  assign out_skip     = out_valid && rd_entry.skip;
  assign out_wen      = out_valid && rd_entry.wen;
  assign out_wdest    = out_valid ? rd_entry.wdest : '0;
  assign out_wdata    = out_valid ? rd_entry.wdata : '0;
  assign count        = count_q;
  assign err_overflow = err_q;

endmodule
